// File: rtl/dadda_4bit.sv
// ---------------------------------------------------------------------------
// dadda_4bit -- 4x4 unsigned multiplier with a single register stage.
//
// The datapath is a Dadda reduction tree followed by a 2-row ripple-carry
// adder. It is purely combinational from the A/B pins up to the prod register.
// Operands are captured on every rising clk edge, and the product appears one
// cycle later. A new operand pair can be applied on every cycle.
//
// Handshake: there is a valid signal only and no ready signal. The block
// cannot stall. in_valid marks that A/B carry a real operand pair on this
// cycle. out_valid is in_valid delayed by exactly one cycle and marks that prod
// belongs to such a pair. prod is updated on every edge whether or not
// in_valid is set, so consumers must qualify it with out_valid.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset; clears prod and out_valid
//   A          in   4  multiplicand, unsigned
//   B          in   4  multiplier, unsigned
//   in_valid   in   1  A/B valid this cycle
//   prod       out  8  registered product A*B
//   out_valid  out  1  prod corresponds to an in_valid pair
// ---------------------------------------------------------------------------
module dadda_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       in_valid,
  output logic [7:0] prod,
  output logic       out_valid
);

  // Partial products: pp[i][j] = A[i] & B[j], weight 2^(i+j).
  logic [3:0] pp [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = {4{A[i]}} & B;
    end
  end

  // Stage 1: the target height is 3. Column 3 (height 4) needs one half
  // adder. Its carry raises column 4 to height 4, so column 4 also needs a
  // half adder.
  logic s1_s3, s1_c4, s1_s4, s1_c5;

  dadda_ha u_s1_ha3 (.a(pp[3][0]), .b(pp[2][1]), .s(s1_s3), .c(s1_c4));
  dadda_ha u_s1_ha4 (.a(pp[3][1]), .b(pp[2][2]), .s(s1_s4), .c(s1_c5));

  // Stage 2: the target height is 2. Column 2 (height 3) needs one half
  // adder. Each carry then pushes the next column to height 4, so columns
  // 3..5 each need a full adder.
  logic s2_s2, s2_c3, s2_s3, s2_c4, s2_s4, s2_c5, s2_s5, s2_c6;

  dadda_ha u_s2_ha2 (.a(pp[2][0]), .b(pp[1][1]), .s(s2_s2), .c(s2_c3));
  dadda_fa u_s2_fa3 (.a(s1_s3), .b(pp[1][2]), .ci(pp[0][3]), .s(s2_s3), .co(s2_c4));
  dadda_fa u_s2_fa4 (.a(s1_s4), .b(pp[1][3]), .ci(s1_c4),    .s(s2_s4), .co(s2_c5));
  dadda_fa u_s2_fa5 (.a(pp[3][2]), .b(pp[2][3]), .ci(s1_c5), .s(s2_s5), .co(s2_c6));

  // Final carry-propagate adder over the two remaining rows.
  // Bit 0 has height 1 and passes straight through. Bit 1 has no
  // carry-in, so it uses a half adder. Bits 2..6 use full adders.
  logic [6:2] row_a;
  logic [6:2] row_b;
  logic [7:2] rc;
  logic [7:0] sum;

  assign row_a = {pp[3][3], s2_s5, s2_s4, s2_s3, s2_s2};
  assign row_b = {s2_c6,    s2_c5, s2_c4, s2_c3, pp[0][2]};

  assign sum[0] = pp[0][0];

  dadda_ha u_cpa_ha1 (.a(pp[1][0]), .b(pp[0][1]), .s(sum[1]), .c(rc[2]));

  for (genvar k = 2; k <= 6; k++) begin : g_cpa
    dadda_fa u_fa (.a(row_a[k]), .b(row_b[k]), .ci(rc[k]), .s(sum[k]), .co(rc[k+1]));
  end

  assign sum[7] = rc[7];

  // Output register. The reset is asynchronous, so a pulse mid-stream
  // discards the result that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod      <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      prod      <= sum;
      out_valid <= in_valid;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// dadda_ha -- half adder.
//   a, b  in  1  addends
//   s     out 1  sum
//   c     out 1  carry
// ---------------------------------------------------------------------------
module dadda_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// ---------------------------------------------------------------------------
// dadda_fa -- full adder.
//   a, b, ci  in  1  addends and carry-in
//   s         out 1  sum
//   co        out 1  carry-out
// ---------------------------------------------------------------------------
module dadda_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: tb/tb_dadda_4bit.sv
// ---------------------------------------------------------------------------
// tb_dadda_4bit -- self-checking bench for dadda_4bit.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, which is half a period after the capturing rising edge.
// The expected queue holds one entry per applied cycle:
//   {check_prod, valid, product}
// ---------------------------------------------------------------------------
module tb_dadda_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [7:0] prod;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  dadda_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .in_valid  (in_valid),
    .prod      (prod),
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the current outputs.
  task automatic check_head();
    logic [9:0] e;
    string      t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e[9]) check_eq({t, "_prod"}, prod, e[7:0]);
      check_eq({t, "_valid"}, {7'b0, out_valid}, {7'b0, e[8]});
    end
  endtask

  // ---------------- driver ----------------
  // Applies one operand pair. The reference is plain integer multiplication.
  task automatic cycle(input logic [3:0] ta, input logic [3:0] tb_, input logic v,
                       input string tag);
    logic       known;
    logic [7:0] m;
    @(negedge clk);
    check_head();
    a        = ta;
    b        = tb_;
    in_valid = v;
    known    = !$isunknown({ta, tb_});
    m        = known ? 8'(int'(ta) * int'(tb_)) : 8'h00;
    exp_q.push_back({known, v, m});
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check_head();
    end
  endtask

  // Asserts reset mid-cycle, just after the inputs are driven, and checks
  // that the outputs clear with no clock edge. It then holds reset across
  // one rising edge and releases it on a falling edge.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_async_prod"}, prod, 8'h00);
    check_eq({tag, "_async_valid"}, {7'b0, out_valid}, 8'h00);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    check_eq({tag, "_hold_prod"}, prod, 8'h00);
    check_eq({tag, "_hold_valid"}, {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    in_valid = 1'b0;
    #3;
    check_eq("reset_prod", prod, 8'h00);
    check_eq("reset_valid", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Corner cases.
    cycle(4'd0,  4'd0,  1'b1, "c_0x0");
    cycle(4'd15, 4'd0,  1'b1, "c_15x0");
    cycle(4'd1,  4'd15, 1'b1, "c_1x15");
    cycle(4'd15, 4'd15, 1'b1, "c_15x15");
    cycle(4'd8,  4'd8,  1'b1, "c_8x8");

    // Carry-chain cases.
    cycle(4'd15, 4'd13, 1'b1, "cc_15x13");
    cycle(4'd13, 4'd15, 1'b1, "cc_13x15");
    cycle(4'd11, 4'd11, 1'b1, "cc_11x11");

    // Valid tracking: the in_valid pattern 1,0,1,1 must appear on
    // out_valid one cycle later.
    cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, "vt0");
    cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, "vt1");
    cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, "vt2");
    cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, "vt3");
    drain();

    // Asynchronous reset mid-cycle while 15x15 is in flight.
    @(negedge clk);
    a = 4'd15; b = 4'd15; in_valid = 1'b1;
    @(posedge clk);
    #2;
    check_eq("pre_rst_prod", prod, 8'd225);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_prod", prod, 8'h00);
    check_eq("mid_rst_valid", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive back-to-back sweep. Reset is pulsed while 7x9 is in
    // flight. 3x5 follows the release, and then 7x9 is applied again so
    // that every pair is checked.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        cycle(4'(i), 4'(j), 1'b1, "sweep");
        if (i == 7 && j == 9) begin
          reset_pulse("sweep_rst");
          cycle(4'd3, 4'd5, 1'b1, "post_rst_3x5");
          cycle(4'd7, 4'd9, 1'b1, "sweep_7x9");
        end
      end
    end

    // Random traffic. Some idle cycles carry X operands, which must not
    // disturb out_valid.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0)
        cycle(4'bxxxx, 4'bxxxx, 1'b0, "rnd_x_idle");
      else
        cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), "rnd");
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
